// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared depth default and FSM state types for the UART FIFO bridge
package uart_fifo_pkg;
  localparam int DEPTH_DEF = 16;
  typedef enum logic [1:0] {T_IDLE, T_SENT, T_WAIT} tx_state_t;
  typedef enum logic {R_IDLE, R_ACK} rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with level-derived full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign head = mem[rp];
  // storage write; contents are meaningless until counted by level, so no reset
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap naturally at DEPTH; level tracks occupancy
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: CSR-side Tx/Rx FIFOs bridging software to a single-byte UART
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       csr_tx_write,
  input  logic [7:0]                 csr_tx_data,
  output logic                       csr_tx_full,
  output logic [$clog2(DEPTH):0]     csr_tx_level,
  input  logic                       csr_rx_read,
  output logic [7:0]                 csr_rx_data,
  output logic                       csr_rx_valid,
  output logic                       csr_rx_oflow,
  output logic                       uart_tx_write,
  output logic [7:0]                 uart_tx_data,
  input  logic                       uart_tx_busy,
  input  logic                       uart_rx_valid,
  input  logic                       uart_rx_oflow,
  input  logic [7:0]                 uart_rx_data,
  output logic                       uart_rx_read
);
  tx_state_t tx_st;
  rx_state_t rx_st;
  logic tx_empty, tx_pop, rx_full, rx_empty, rx_cap, rx_push;
  logic [7:0] tx_head, rx_hold;
  logic [$clog2(DEPTH):0] rx_level;
  logic unused_rx_level;
  assign tx_pop = tx_st == T_IDLE && !tx_empty && !uart_tx_busy;
  assign rx_cap = rx_st == R_IDLE && uart_rx_valid && !rx_full;
  assign rx_push = rx_st == R_ACK;
  assign csr_rx_valid = !rx_empty;
  assign unused_rx_level = ^rx_level;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .arst(arst), .push(csr_tx_write), .pop(tx_pop), .din(csr_tx_data),
    .head(tx_head), .full(csr_tx_full), .empty(tx_empty), .level(csr_tx_level)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .arst(arst), .push(rx_push), .pop(csr_rx_read), .din(rx_hold),
    .head(csr_rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );
  // Tx drain: one pulse per byte, then wait for the UART to report busy and finish
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      tx_st <= T_IDLE;
      uart_tx_write <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      case (tx_st)
        T_IDLE: if (tx_pop) begin
          uart_tx_write <= 1'b1;
          uart_tx_data <= tx_head;
          tx_st <= T_SENT;
        end
        T_SENT: begin
          uart_tx_write <= 1'b0;
          tx_st <= T_WAIT;
        end
        default: if (!uart_tx_busy) tx_st <= T_IDLE;
      endcase
    end
  // Rx capture: latch the UART byte with a read pulse, push it on the following cycle
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      rx_st <= R_IDLE;
      uart_rx_read <= 1'b0;
      rx_hold <= '0;
      csr_rx_oflow <= 1'b0;
    end else begin
      rx_st <= rx_cap ? R_ACK : R_IDLE;
      uart_rx_read <= rx_cap;
      if (rx_cap) rx_hold <= uart_rx_data;
      csr_rx_oflow <= (rx_cap && uart_rx_oflow) || (csr_rx_oflow && !csr_rx_read);
    end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: scoreboard bench for the UART FIFO bridge
module tb_uart_fifo;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic csr_tx_write = 1'b0;
  logic [7:0] csr_tx_data = '0;
  logic csr_tx_full;
  logic [LW-1:0] csr_tx_level;
  logic csr_rx_read = 1'b0;
  logic [7:0] csr_rx_data;
  logic csr_rx_valid, csr_rx_oflow;
  logic uart_tx_write;
  logic [7:0] uart_tx_data;
  logic uart_tx_busy;
  logic uart_rx_valid, uart_rx_oflow;
  logic [7:0] uart_rx_data;
  logic uart_rx_read;
  logic hold_busy = 1'b0;
  int busy_cnt;
  logic ld = 1'b0, ld_of = 1'b0;
  logic [7:0] ld_d = '0;
  int tests = 0, fails = 0, tx_pulses = 0, rx_reads = 0;
  logic prev_w = 1'b0;
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  logic [7:0] te, re;

  uart_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .arst(arst),
    .csr_tx_write(csr_tx_write), .csr_tx_data(csr_tx_data),
    .csr_tx_full(csr_tx_full), .csr_tx_level(csr_tx_level),
    .csr_rx_read(csr_rx_read), .csr_rx_data(csr_rx_data),
    .csr_rx_valid(csr_rx_valid), .csr_rx_oflow(csr_rx_oflow),
    .uart_tx_write(uart_tx_write), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid), .uart_rx_oflow(uart_rx_oflow),
    .uart_rx_data(uart_rx_data), .uart_rx_read(uart_rx_read)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 87 cycles after each accepted pulse
  always @(posedge clk or posedge arst)
    if (arst) busy_cnt <= 0;
    else if (uart_tx_write) busy_cnt <= 87;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign uart_tx_busy = hold_busy || busy_cnt != 0;

  // UART receiver holding register model: loaded by the bench, cleared on read
  always @(posedge clk or posedge arst)
    if (arst) begin
      uart_rx_valid <= 1'b0;
      uart_rx_data <= '0;
      uart_rx_oflow <= 1'b0;
    end else if (ld) begin
      uart_rx_valid <= 1'b1;
      uart_rx_data <= ld_d;
      uart_rx_oflow <= ld_of;
    end else if (uart_rx_read) uart_rx_valid <= 1'b0;

  // Output monitors: pop scoreboards as the DUT emits Tx bytes and SW pops Rx bytes
  always @(negedge clk) begin
    if (!arst && uart_tx_write) begin
      tx_pulses++;
      tests++;
      if (tx_exp.size() == 0) begin
        fails++;
        $display("FAIL tx_byte got %h, no byte expected", uart_tx_data);
      end else begin
        te = tx_exp.pop_front();
        if (uart_tx_data !== te) begin
          fails++;
          $display("FAIL tx_byte got %h want %h", uart_tx_data, te);
        end
      end
      tests++;
      if (prev_w || uart_tx_busy !== 1'b0) begin
        fails++;
        $display("FAIL tx_pulse_shape prev_write=%b busy=%b want 0/0", prev_w, uart_tx_busy);
      end
    end
    if (!arst && csr_rx_read && csr_rx_valid) begin
      tests++;
      if (rx_exp.size() == 0) begin
        fails++;
        $display("FAIL rx_byte got %h, no byte expected", csr_rx_data);
      end else begin
        re = rx_exp.pop_front();
        if (csr_rx_data !== re) begin
          fails++;
          $display("FAIL rx_byte got %h want %h", csr_rx_data, re);
        end
      end
    end
    if (!arst && uart_rx_read) rx_reads++;
    prev_w = uart_tx_write && !arst;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d, input bit acc);
    csr_tx_write = 1'b1;
    csr_tx_data = d;
    if (acc) tx_exp.push_back(d);
    tick(1);
    csr_tx_write = 1'b0;
  endtask

  task automatic rx_load(input logic [7:0] d, input logic of);
    ld = 1'b1;
    ld_d = d;
    ld_of = of;
    rx_exp.push_back(d);
    tick(1);
    ld = 1'b0;
  endtask

  task automatic sw_read;
    csr_rx_read = 1'b1;
    tick(1);
    csr_rx_read = 1'b0;
  endtask

  task automatic wait_tx_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (tx_exp.size() == 0 && !uart_tx_busy && !uart_tx_write) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_reset;
    arst = 1'b1;
    tick(3);
    tests++;
    if ({csr_tx_full, csr_rx_valid, csr_rx_oflow, uart_tx_write, uart_rx_read} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000",
               {csr_tx_full, csr_rx_valid, csr_rx_oflow, uart_tx_write, uart_rx_read});
    end
    tests++;
    if (csr_tx_level !== '0) begin
      fails++;
      $display("FAIL reset_level got %0d want 0", csr_tx_level);
    end
    tests++;
    if (uart_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx_data got %h want 00", uart_tx_data);
    end
    arst = 1'b0;
    tick(2);
  endtask

  task automatic test_tx_order;
    int p0;
    bit ok, seen;
    p0 = tx_pulses;
    push_tx(8'h55, 1'b1);
    tick(1);
    seen = uart_tx_write;
    if (!seen) begin
      tick(1);
      seen = uart_tx_write;
    end
    tests++;
    if (seen !== 1'b1) begin
      fails++;
      $display("FAIL tx_latency pulse seen=%b within 2 cycles, want 1", seen);
    end
    push_tx(8'hAA, 1'b1);
    push_tx(8'h0F, 1'b1);
    wait_tx_idle(1000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL tx_order_timeout pending=%0d want 0", tx_exp.size());
    end
    tests++;
    if (tx_pulses - p0 !== 3) begin
      fails++;
      $display("FAIL tx_order_count got %0d want 3", tx_pulses - p0);
    end
  endtask

  task automatic test_tx_full;
    int p0;
    bit ok;
    p0 = tx_pulses;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_tx(8'(i), 1'b1);
    tests++;
    if (csr_tx_full !== 1'b1 || csr_tx_level !== LW'(16)) begin
      fails++;
      $display("FAIL tx_full got full=%b level=%0d want 1/16", csr_tx_full, csr_tx_level);
    end
    push_tx(8'h10, 1'b0);
    tests++;
    if (csr_tx_full !== 1'b1 || csr_tx_level !== LW'(16)) begin
      fails++;
      $display("FAIL tx_drop got full=%b level=%0d want 1/16", csr_tx_full, csr_tx_level);
    end
    hold_busy = 1'b0;
    wait_tx_idle(3000, ok);
    tests++;
    if (!ok || tx_pulses - p0 !== 16 || csr_tx_level !== '0) begin
      fails++;
      $display("FAIL tx_drain got ok=%b pulses=%0d level=%0d want 1/16/0", ok, tx_pulses - p0, csr_tx_level);
    end
  endtask

  task automatic test_rx_single;
    int p0;
    p0 = rx_reads;
    rx_load(8'h41, 1'b0);
    tick(1);
    tests++;
    if (csr_rx_valid !== 1'b0 || uart_rx_read !== 1'b1) begin
      fails++;
      $display("FAIL rx_capture got valid=%b read=%b want 0/1", csr_rx_valid, uart_rx_read);
    end
    tick(1);
    tests++;
    if (csr_rx_valid !== 1'b1 || csr_rx_data !== 8'h41) begin
      fails++;
      $display("FAIL rx_latency got valid=%b data=%h want 1/41", csr_rx_valid, csr_rx_data);
    end
    tick(5);
    tests++;
    if (rx_reads - p0 !== 1) begin
      fails++;
      $display("FAIL rx_read_pulses got %0d want 1", rx_reads - p0);
    end
    sw_read();
    tests++;
    if (csr_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rx_no_dup got valid=%b want 0", csr_rx_valid);
    end
    sw_read();
    tick(1);
    tests++;
    if (csr_rx_valid !== 1'b0 || csr_rx_oflow !== 1'b0) begin
      fails++;
      $display("FAIL rx_empty_read got valid=%b oflow=%b want 0/0", csr_rx_valid, csr_rx_oflow);
    end
  endtask

  task automatic test_rx_full;
    int p0, n;
    for (int i = 0; i < 16; i++) begin
      rx_load(8'h80 + 8'(i), 1'b0);
      tick(3);
    end
    p0 = rx_reads;
    rx_load(8'h99, 1'b0);
    tick(10);
    tests++;
    if (rx_reads !== p0 || uart_rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL rx_full_hold got reads=%0d uart_valid=%b want 0/1", rx_reads - p0, uart_rx_valid);
    end
    sw_read();
    tick(5);
    tests++;
    if (rx_reads - p0 !== 1 || uart_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rx_full_resume got reads=%0d uart_valid=%b want 1/0", rx_reads - p0, uart_rx_valid);
    end
    n = 0;
    for (int i = 0; i < 20 && csr_rx_valid; i++) begin
      sw_read();
      n++;
    end
    tests++;
    if (n !== 16 || rx_exp.size() !== 0) begin
      fails++;
      $display("FAIL rx_full_level got entries=%0d pending=%0d want 16/0", n, rx_exp.size());
    end
  endtask

  task automatic test_oflow;
    rx_load(8'h22, 1'b0);
    tick(3);
    tests++;
    if (csr_rx_oflow !== 1'b0) begin
      fails++;
      $display("FAIL oflow_clean got %b want 0", csr_rx_oflow);
    end
    rx_load(8'h33, 1'b1);
    csr_rx_read = 1'b1;
    tick(1);
    csr_rx_read = 1'b0;
    tests++;
    if (csr_rx_oflow !== 1'b1) begin
      fails++;
      $display("FAIL oflow_set_wins got %b want 1", csr_rx_oflow);
    end
    tick(2);
    sw_read();
    tests++;
    if (csr_rx_oflow !== 1'b0 || csr_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL oflow_clear got oflow=%b valid=%b want 0/0", csr_rx_oflow, csr_rx_valid);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_tx(8'hC0 + 8'(i), 1'b0);
    hold_busy = 1'b0;
    tick(1);
    tests++;
    if (uart_tx_write !== 1'b1 || csr_tx_level !== LW'(5)) begin
      fails++;
      $display("FAIL mid_sent got write=%b level=%0d want 1/5", uart_tx_write, csr_tx_level);
    end
    arst = 1'b1;
    #1;
    tests++;
    if (uart_tx_write !== 1'b0 || csr_tx_level !== '0 || csr_tx_full !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got write=%b level=%0d full=%b want 0/0/0", uart_tx_write, csr_tx_level, csr_tx_full);
    end
    tick(2);
    arst = 1'b0;
    p0 = tx_pulses;
    tick(300);
    tests++;
    if (tx_pulses !== p0) begin
      fails++;
      $display("FAIL mid_no_pulse got %0d pulses want 0", tx_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_single();
    test_rx_full();
    test_oflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 16, entries per FIFO; power of 2, 4..64.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on posedge.
REQ-003 SHALL have port: arst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: csr_tx_write  input  1  SW push strobe, one cycle per byte.
REQ-005 SHALL have port: csr_tx_data  input  8  byte to push.
REQ-006 SHALL have port: csr_tx_full  output  1  Tx FIFO full.
REQ-007 SHALL have port: csr_tx_level  output  $clog2(DEPTH)+1  Tx FIFO occupancy.
REQ-008 SHALL have port: csr_rx_read  input  1  SW pop strobe.
REQ-009 SHALL have port: csr_rx_data  output  8  Rx FIFO head (show-ahead).
REQ-010 SHALL have port: csr_rx_valid  output  1  Rx FIFO non-empty.
REQ-011 SHALL have port: csr_rx_oflow  output  1  sticky Rx-loss flag.
REQ-012 SHALL have port: uart_tx_write  output  1  registered push pulse to UART.
REQ-013 SHALL have port: uart_tx_data  output  8  registered byte to UART.
REQ-014 SHALL have port: uart_tx_busy  input  1  UART transmitter busy.
REQ-015 SHALL have ports: uart_rx_valid, uart_rx_oflow  input  1 each; uart_rx_data  input  8: UART single-byte Rx holding register.
REQ-016 SHALL have port: uart_rx_read  output  1  registered clear-on-read pulse to UART.

Function
REQ-017 Tx push: accept csr_tx_write only when csr_tx_full=0 at that cycle, even if a pop occurs the same cycle; a write while full is dropped silently.
REQ-018 Tx drain FSM SHALL use states T_IDLE, T_SENT, T_WAIT.
REQ-019 T_IDLE: if FIFO non-empty and uart_tx_busy=0, then uart_tx_write<=1, uart_tx_data<=head, pop, go to T_SENT.
REQ-020 T_SENT: uart_tx_write<=0; go to T_WAIT unconditionally, which lets busy rise.
REQ-021 T_WAIT: when uart_tx_busy=0, go to T_IDLE.
REQ-022 uart_tx_write SHALL be exactly one cycle wide, and at most one pulse per UART byte.
REQ-023 Rx capture FSM SHALL use states R_IDLE, R_ACK.
REQ-024 R_IDLE: if uart_rx_valid=1 and Rx FIFO not full, then push uart_rx_data, uart_rx_read<=1, go to R_ACK.
REQ-025 R_ACK: uart_rx_read<=0; return to R_IDLE, so the same byte is never captured twice.
REQ-026 Rx FIFO full: leave the byte in the UART with no read pulse; UART-side overflow then accumulates.
REQ-027 csr_rx_oflow SHALL be set when a capture sees uart_rx_oflow=1.
REQ-028 csr_rx_oflow SHALL be cleared by csr_rx_read; set wins over a simultaneous clear.
REQ-029 csr_rx_read on an empty FIFO SHALL be ignored; csr_rx_data is don't-care when csr_rx_valid=0.
REQ-030 Simultaneous push and pop on the Rx FIFO SHALL be allowed; level stays unchanged.
REQ-031 Pointers SHALL wrap modulo DEPTH; full/empty are derived from a (log2 DEPTH)+1-bit level counter.
REQ-032 Latency: CSR push to uart_tx_write SHALL be at most 2 cycles when UART is idle; uart_rx_valid to csr_rx_valid SHALL be 2 cycles.

Reset
REQ-033 On arst, asynchronously and immediately: both FIFOs empty, csr_tx_full=0, csr_tx_level=0, csr_rx_valid=0, csr_rx_oflow=0, uart_tx_write=0, uart_tx_data=0, uart_rx_read=0, FSMs in T_IDLE/R_IDLE.
REQ-034 Reset mid-transfer SHALL discard FIFO contents; no pulse is emitted after deassertion until new data arrives.
REQ-035 FIFO storage array SHALL NOT require reset.

Structure
REQ-036 A shared package uart_fifo_pkg SHALL hold the DEPTH default and the tx_state_t / rx_state_t enums.
REQ-037 A single sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level/head) SHALL be instantiated twice: Tx and Rx.
REQ-038 Target size: 150-300 lines RTL total.

Verification
REQ-039 Push 0x55,0xAA,0x0F with a UART model busy for 87 cycles each -> exactly three uart_tx_write pulses carrying 0x55,0xAA,0x0F in order, each only after busy falls.
REQ-040 DEPTH=16, hold busy=1, push 17 bytes 0x00..0x10 -> csr_tx_full=1 after 16, level=16, 0x10 dropped; release busy -> 0x00..0x0F sent.
REQ-041 Model presents 0x41 with valid=1 -> one uart_rx_read pulse, csr_rx_data=0x41, csr_rx_valid=1 two cycles later; no duplicate entry.
REQ-042 Fill Rx FIFO with 16 bytes, present 0x99 -> no uart_rx_read; SW reads one -> 0x99 captured next, level back to 16.
REQ-043 Capture with uart_rx_oflow=1 on the same cycle as csr_rx_read -> csr_rx_oflow stays 1; next read clears it.
REQ-044 Assert arst during T_SENT with 5 bytes queued -> uart_tx_write=0 immediately, level=0, no further pulses.
